cache_pmem_arbiter: RTL and testbench

- Sits directly downstream of the split instruction and data caches. Sits upstream of physical memory.
- Accepts line-granularity read requests from the I-cache and read/write requests from the D-cache. Serializes them onto the single pmem port.
- Latches the winning request and holds the pmem outputs stable until memory responds. Returns a registered line and a one-cycle resp to the granted cache.
- Keeps a saturating count of contended arbitrations for performance analysis.

---
 rtl/lc3b_types.sv | 29 ++
 rtl/sat_counter.sv | 34 +++
 rtl/cache_pmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_cache_pmem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the cache / physical-memory arbiter.
//   lc3b_word     : 16-bit byte address
//   lc3b_8word    : 128-bit cache line (eight 16-bit words)
//   arb_state_t   : arbiter FSM states
//   arb_client_t  : which cache owns (or last owned) the pmem port
//   arb_op_t      : latched memory operation for the granted request
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_8word;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } arb_client_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk      : clock
//   clear_i  : synchronous clear (highest priority)
//   inc_i    : increment request for this cycle
//   value_o  : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc_i && (value_q != '1)) begin
      value_d = value_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/cache_pmem_arbiter.sv
// Arbiter between the split I-cache and D-cache and the single physical
// memory port. Requests are line-granularity; the winner's address/op/wdata
// are latched so pmem outputs stay stable while memory is busy, the returned
// line is registered per client, and a one-cycle resp goes to the winner.
//   clk, reset                       : clock, synchronous active-high reset
//   i_pmem_read/_address             : I-cache read request (level)
//   i_pmem_rdata/_resp               : line and completion pulse to I-cache
//   d_pmem_read/_write/_address/_wdata : D-cache request (level)
//   d_pmem_rdata/_resp               : line and completion pulse to D-cache
//   pmem_read/_write/_address/_wdata : request to physical memory
//   pmem_rdata/_resp                 : memory return
//   conflict_count                   : saturating count of contended IDLE cycles
module cache_pmem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = $bits(lc3b_word),
  parameter int LINE_WIDTH = $bits(lc3b_8word),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic [CNT_WIDTH-1:0]  conflict_count
);

  arb_state_t            state_q, state_d;
  arb_client_t           last_grant_q, last_grant_d;
  arb_op_t               op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic i_req, d_req, contended;

  assign i_req     = i_pmem_read;
  assign d_req     = d_pmem_read | d_pmem_write;
  assign contended = (state_q == IDLE) && i_req && d_req;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie the client that did not win last time gets the port.
        if (i_req && (!d_req || (last_grant_q == CLIENT_D))) begin
          state_d      = I_BUSY;
          last_grant_d = CLIENT_I;
          op_d         = OP_READ;
          addr_d       = i_pmem_address;
        end else if (d_req) begin
          state_d      = D_BUSY;
          last_grant_d = CLIENT_D;
          // Read and write together is illegal; the writeback is honoured.
          op_d         = d_pmem_write ? OP_WRITE : OP_READ;
          addr_d       = d_pmem_address;
          wdata_d      = d_pmem_wdata;
        end
      end
      I_BUSY: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_rdata_d = pmem_rdata;
          state_d   = RESP;
        end
      end
      D_BUSY: begin
        pmem_read  = (op_q == OP_READ);
        pmem_write = (op_q == OP_WRITE);
        if (pmem_resp) begin
          if (op_q == OP_READ) begin
            d_rdata_d = pmem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        // last_grant_q was written at grant time, so it names the current owner.
        // The unconditional return to IDLE gives the cache a cycle to drop
        // its request before it could be re-arbitrated.
        i_pmem_resp = (last_grant_q == CLIENT_I);
        d_pmem_resp = (last_grant_q == CLIENT_D);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= CLIENT_D;
      op_q         <= OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_pmem_rdata = i_rdata_q;
  assign d_pmem_rdata = d_rdata_q;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_conflict_cnt (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (contended),
    .value_o (conflict_count)
  );

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Directed bench for cache_pmem_arbiter: a scoreboard of expected client
// responses is filled as requests are issued and drained by a response
// monitor; memory is driven directly from the stimulus sequence.
module tb_cache_pmem_arbiter;

  logic         clk;
  logic         reset;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  conflict_count;

  typedef struct {
    logic         is_d;
    logic [127:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  cache_pmem_arbiter #(
    .ADDR_WIDTH (16),
    .LINE_WIDTH (128),
    .CNT_WIDTH  (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .conflict_count (conflict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic is_d, input logic [127:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    sb.push_back(e);
  endtask

  // Response monitor: every client resp must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      check("pmem_rw_overlap", 128'(pmem_read & pmem_write), 128'(1'b0));
      if (i_pmem_resp || d_pmem_resp) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 128'({d_pmem_resp, i_pmem_resp}), 128'(2'b00));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_client", 128'({d_pmem_resp, i_pmem_resp}),
                128'(e.is_d ? 2'b10 : 2'b01));
          check("resp_rdata", e.is_d ? d_pmem_rdata : i_pmem_rdata, e.data);
        end
      end
    end
  end

  // Called at the negedge of the first busy cycle; checks the held request
  // every cycle, answers in busy cycle wait_cycles+1, returns at RESP negedge.
  task automatic mem_respond(input int wait_cycles, input logic [127:0] data,
                             input logic is_write, input logic [15:0] addr,
                             input logic [127:0] wdata);
    for (int k = 0; k <= wait_cycles; k++) begin
      check("pmem_read_held",    128'(pmem_read),    128'(!is_write));
      check("pmem_write_held",   128'(pmem_write),   128'(is_write));
      check("pmem_address_held", 128'(pmem_address), 128'(addr));
      if (is_write) check("pmem_wdata_held", pmem_wdata, wdata);
      if (k == wait_cycles) begin
        pmem_resp  = 1'b1;
        pmem_rdata = data;
      end
      tick(1);
    end
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    check("pmem_req_dropped", 128'({pmem_read, pmem_write}), 128'(2'b00));
  endtask

  // At RESP negedge: one-cycle pulse to the right client only.
  task automatic resp_pulse(input logic is_d);
    check("i_resp_pulse", 128'(i_pmem_resp), 128'(!is_d));
    check("d_resp_pulse", 128'(d_pmem_resp), 128'(is_d));
    if (is_d) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end else begin
      i_pmem_read = 1'b0;
    end
    tick(1);
    check("resp_one_cycle", 128'({d_pmem_resp, i_pmem_resp}), 128'(2'b00));
  endtask

  // Both caches request in the same IDLE cycle; I is expected to win.
  task automatic tie_round(input logic [15:0] ai, input logic [15:0] ad,
                           input logic [127:0] ri, input logic [127:0] rd);
    i_pmem_read    = 1'b1;
    i_pmem_address = ai;
    d_pmem_read    = 1'b1;
    d_pmem_address = ad;
    push_exp(1'b0, ri);
    push_exp(1'b1, rd);
    tick(1);
    mem_respond(0, ri, 1'b0, ai, '0);
    resp_pulse(1'b0);
    tick(1);
    mem_respond(0, rd, 1'b0, ad, '0);
    resp_pulse(1'b1);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    i_pmem_read    = 1'b0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    pmem_resp      = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d assertions evaluated", n_assert);
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_pmem_address = '0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;

    // Reset state (checked while reset is still asserted)
    reset        = 1'b1;
    i_pmem_read  = 1'b0;
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    pmem_resp    = 1'b0;
    tick(2);
    check("rst_pmem_read",  128'(pmem_read),      128'(1'b0));
    check("rst_pmem_write", 128'(pmem_write),     128'(1'b0));
    check("rst_resp",       128'({d_pmem_resp, i_pmem_resp}), 128'(2'b00));
    check("rst_address",    128'(pmem_address),   128'(16'h0));
    check("rst_wdata",      pmem_wdata,           '0);
    check("rst_i_rdata",    i_pmem_rdata,         '0);
    check("rst_d_rdata",    d_pmem_rdata,         '0);
    check("rst_conflict",   128'(conflict_count), 128'(16'h0));
    reset = 1'b0;
    tick(1);

    // I-cache only read, memory answers in the 4th busy cycle
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1230;
    push_exp(1'b0, {16{8'hA5}});
    tick(1);
    mem_respond(3, {16{8'hA5}}, 1'b0, 16'h1230, '0);
    resp_pulse(1'b0);
    check("i_rdata_holds", i_pmem_rdata, {16{8'hA5}});
    check("d_rdata_untouched", d_pmem_rdata, '0);

    // D-cache writeback; inputs change after the grant
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h4560;
    d_pmem_wdata   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    push_exp(1'b1, '0);
    tick(1);
    d_pmem_address = 16'hFFFF;
    d_pmem_wdata   = '1;
    d_pmem_write   = 1'b0;
    d_pmem_read    = 1'b1;
    mem_respond(2, {8{16'hDEAD}}, 1'b1, 16'h4560,
                128'h0123456789ABCDEF_FEDCBA9876543210);
    resp_pulse(1'b1);
    check("wb_d_rdata_unchanged", d_pmem_rdata, '0);
    check("wb_i_rdata_unchanged", i_pmem_rdata, {16{8'hA5}});

    // Tie after reset: I first, then D; a second tie again goes to I
    do_reset();
    tick(1);
    tie_round(16'h1000, 16'h2000, {8{16'h1111}}, {8{16'h2222}});
    check("tie1_conflict", 128'(conflict_count), 128'(16'd1));
    tie_round(16'h1010, 16'h2020, {8{16'h3333}}, {8{16'h4444}});
    check("tie2_conflict", 128'(conflict_count), 128'(16'd2));

    // Back-to-back: D arrives while I is busy
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h3000;
    push_exp(1'b0, {8{16'h5555}});
    tick(1);
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h4000;
    push_exp(1'b1, {8{16'h6666}});
    mem_respond(1, {8{16'h5555}}, 1'b0, 16'h3000, '0);
    // RESP cycle
    resp_pulse(1'b0);
    // IDLE cycle: still no memory request
    check("b2b_idle_gap", 128'({pmem_read, pmem_write}), 128'(2'b00));
    tick(1);
    check("b2b_d_start", 128'(pmem_read), 128'(1'b1));
    mem_respond(0, {8{16'h6666}}, 1'b0, 16'h4000, '0);
    resp_pulse(1'b1);
    check("b2b_conflict", 128'(conflict_count), 128'(16'd2));

    // Reset in D_BUSY, then a spurious memory response
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h5000;
    tick(1);
    check("mid_busy", 128'(pmem_read), 128'(1'b1));
    reset = 1'b1;
    tick(1);
    check("mid_rst_req",      128'({pmem_read, pmem_write}), 128'(2'b00));
    check("mid_rst_resp",     128'({d_pmem_resp, i_pmem_resp}), 128'(2'b00));
    check("mid_rst_conflict", 128'(conflict_count), 128'(16'h0));
    reset       = 1'b0;
    d_pmem_read = 1'b0;
    pmem_resp   = 1'b1;
    pmem_rdata  = {8{16'h9999}};
    tick(1);
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    check("spurious_no_req",  128'({pmem_read, pmem_write}), 128'(2'b00));
    check("spurious_d_rdata", d_pmem_rdata, '0);
    tick(1);
    check("spurious_no_resp", 128'({d_pmem_resp, i_pmem_resp}), 128'(2'b00));

    // Saturation from 0xFFFE
    force dut.u_conflict_cnt.value_q = 16'hFFFE;
    tick(1);
    release dut.u_conflict_cnt.value_q;
    check("sat_preload", 128'(conflict_count), 128'(16'hFFFE));
    tie_round(16'h0100, 16'h0200, {8{16'h7777}}, {8{16'h8888}});
    check("sat_reach", 128'(conflict_count), 128'(16'hFFFF));
    tie_round(16'h0110, 16'h0210, {8{16'hABCD}}, {8{16'hBCDE}});
    tie_round(16'h0120, 16'h0220, {8{16'hCDEF}}, {8{16'hDEF0}});
    check("sat_no_wrap", 128'(conflict_count), 128'(16'hFFFF));

    tick(2);
    check("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
